// File: rtl/lamp_fpu_sqrt_issue.sv
// Square-root issue/pack stage: unpacks one operand, resolves special cases
// locally, drives the sqrt core, then rounds (RNE) and repacks its result.
module lamp_fpu_sqrt_issue #(
    parameter int E_DW           = 8,
    parameter int F_DW           = 7,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [E_DW+F_DW:0]    op_i,
    output logic                  doSqrt_o,
    output logic                  signum_op_o,
    output logic [E_DW:0]         extExp_op_o,
    output logic [F_DW:0]         extMant_op_o,
    output logic                  isInf_op_o,
    output logic                  isZero_op_o,
    input  logic                  s_res_i,
    input  logic [E_DW-1:0]       e_res_i,
    input  logic [F_DW+4:0]       f_res_i,
    input  logic                  valid_i,
    input  logic                  isOverflow_i,
    input  logic                  isUnderflow_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [E_DW+F_DW:0]    res_o,
    output logic [4:0]            flags_o
);
    localparam int OPW = 1 + E_DW + F_DW;
    localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [E_DW-1:0] EMAX = '1;
    localparam logic [OPW-1:0]  QNAN = {1'b0, EMAX, 1'b1, {(F_DW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ROUND, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_sgn, r_isInf, r_isZero;
    logic [E_DW:0]     r_extExp;
    logic [F_DW:0]     r_extMant;
    logic              r_s, r_ovf, r_unf;
    logic [E_DW-1:0]   r_e;
    logic [F_DW+4:0]   r_f;
    logic [OPW-1:0]    r_res;
    logic [4:0]        r_flags;

    // operand classification
    logic              w_s, w_eMax, w_eZero, w_fZero, w_nan, w_inf, w_zero, w_special;
    logic [E_DW-1:0]   w_e;
    logic [F_DW-1:0]   w_f;
    logic [OPW-1:0]    w_sp_res;
    logic [4:0]        w_sp_flags;

    assign w_s       = op_i[OPW-1];
    assign w_e       = op_i[OPW-2 -: E_DW];
    assign w_f       = op_i[F_DW-1:0];
    assign w_eMax    = &w_e;
    assign w_eZero   = ~|w_e;
    assign w_fZero   = ~|w_f;
    assign w_nan     = w_eMax & ~w_fZero;
    assign w_inf     = w_eMax & w_fZero;
    assign w_zero    = w_eZero & w_fZero;
    assign w_special = w_eMax | w_zero | w_s;

    // NaN is checked before sign so a negative qNaN stays quiet
    always_comb begin
        w_sp_res   = op_i;
        w_sp_flags = '0;
        if (w_nan) begin
            w_sp_res      = QNAN;
            w_sp_flags[4] = ~w_f[F_DW-1];
        end else if (w_s && !w_zero) begin
            w_sp_res      = QNAN;
            w_sp_flags[4] = 1'b1;
        end
    end

    // round-to-nearest-even on the captured core mantissa
    logic              w_inc, w_carry, w_inexact;
    logic [F_DW+1:0]   w_mant;
    logic [E_DW:0]     w_exp;
    logic [OPW-1:0]    w_rnd_res;
    logic [4:0]        w_rnd_flags;

    assign w_inexact = r_f[3] | (|r_f[2:0]);
    assign w_inc     = r_f[3] & ((|r_f[2:0]) | r_f[4]);
    assign w_mant    = {1'b0, r_f[F_DW+4:4]} + (F_DW+2)'(w_inc);
    assign w_carry   = w_mant[F_DW+1];
    assign w_exp     = {1'b0, r_e} + (E_DW+1)'(w_carry);

    always_comb begin
        w_rnd_res   = {r_s, w_exp[E_DW-1:0], w_mant[F_DW-1:0]};
        w_rnd_flags = {3'b000, w_inexact, 1'b0};
        if (r_ovf) begin
            w_rnd_res   = {r_s, EMAX, {F_DW{1'b0}}};
            w_rnd_flags = 5'b01010;
        end else if (r_unf) begin
            w_rnd_res   = {r_s, {E_DW{1'b0}}, {F_DW{1'b0}}};
            w_rnd_flags = 5'b00110;
        end else if (w_exp >= {1'b0, EMAX}) begin
            w_rnd_res   = {r_s, EMAX, {F_DW{1'b0}}};
            w_rnd_flags = {1'b0, 1'b1, 1'b0, w_inexact, 1'b0};
        end
    end

    logic w_timeout;
    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        req_ready_o = 1'b0;
        doSqrt_o    = 1'b0;
        res_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) w_next = w_special ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                doSqrt_o = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                if (valid_i)        w_next = S_ROUND;
                else if (w_timeout) w_next = S_DONE;
            end
            S_ROUND: w_next = S_DONE;
            S_DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_sgn     <= 1'b0;
            r_isInf   <= 1'b0;
            r_isZero  <= 1'b0;
            r_extExp  <= '0;
            r_extMant <= '0;
            r_s       <= 1'b0;
            r_e       <= '0;
            r_f       <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_res     <= '0;
            r_flags   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid_i) begin
                    r_sgn     <= w_s;
                    r_extExp  <= (w_eZero && !w_fZero) ? (E_DW+1)'(1) : {1'b0, w_e};
                    r_extMant <= {~w_eZero, w_f};
                    r_isInf   <= w_inf;
                    r_isZero  <= w_zero;
                    if (w_special) begin
                        r_res   <= w_sp_res;
                        r_flags <= w_sp_flags;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (valid_i) begin
                        r_s   <= s_res_i;
                        r_e   <= e_res_i;
                        r_f   <= f_res_i;
                        r_ovf <= isOverflow_i;
                        r_unf <= isUnderflow_i;
                    end else if (w_timeout) begin
                        r_res   <= QNAN;
                        r_flags <= 5'b10001;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ROUND: begin
                    r_res   <= w_rnd_res;
                    r_flags <= w_rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign signum_op_o  = r_sgn;
    assign extExp_op_o  = r_extExp;
    assign extMant_op_o = r_extMant;
    assign isInf_op_o   = r_isInf;
    assign isZero_op_o  = r_isZero;
    assign res_o        = r_res;
    assign flags_o      = r_flags;

endmodule

// File: tb/tb_lamp_fpu_sqrt_issue.sv
// Scoreboard bench for lamp_fpu_sqrt_issue with a scripted sqrt-core model.
module tb_lamp_fpu_sqrt_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [15:0] op_i = '0;
    logic        doSqrt_o, signum_op_o, isInf_op_o, isZero_op_o;
    logic [8:0]  extExp_op_o;
    logic [7:0]  extMant_op_o;
    logic        s_res_i = 1'b0;
    logic [7:0]  e_res_i = '0;
    logic [11:0] f_res_i = '0;
    logic        valid_i = 1'b0, isOverflow_i = 1'b0, isUnderflow_i = 1'b0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [15:0] res_o;
    logic [4:0]  flags_o;

    lamp_fpu_sqrt_issue dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .op_i(op_i),
        .doSqrt_o(doSqrt_o), .signum_op_o(signum_op_o), .extExp_op_o(extExp_op_o),
        .extMant_op_o(extMant_op_o), .isInf_op_o(isInf_op_o), .isZero_op_o(isZero_op_o),
        .s_res_i(s_res_i), .e_res_i(e_res_i), .f_res_i(f_res_i), .valid_i(valid_i),
        .isOverflow_i(isOverflow_i), .isUnderflow_i(isUnderflow_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_o(res_o), .flags_o(flags_o)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] res; logic [4:0] flags; } exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   dosqrt_cnt = 0;

    always @(negedge clk) if (doSqrt_o) dosqrt_cnt <= dosqrt_cnt + 1;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic accept(input logic [15:0] op);
        req_valid_i = 1'b1; op_i = op;
        step();
        req_valid_i = 1'b0;
    endtask

    // core model: wait dly cycles, present one result, measure cycles to res_valid_o
    task automatic core_respond(input int dly, input logic [7:0] e, input logic [11:0] f,
                                input logic ov, input logic un, output int lat);
        repeat (dly) step();
        s_res_i = 1'b0; e_res_i = e; f_res_i = f;
        isOverflow_i = ov; isUnderflow_i = un; valid_i = 1'b1;
        step();
        valid_i = 1'b0; isOverflow_i = 1'b0; isUnderflow_i = 1'b0;
        lat = 1;
        while (!res_valid_o && lat < 20) begin step(); lat++; end
    endtask

    task automatic release_res();
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready_o); end
        n_cmp++; if (res_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid_o); end
        n_cmp++; if ({doSqrt_o, signum_op_o, extExp_op_o, extMant_op_o, isInf_op_o, isZero_op_o} !== 21'h0) begin
            n_bad++; $display("FAIL reset_core_outs: got %b/%h/%h want 0", doSqrt_o, extExp_op_o, extMant_op_o); end
        n_cmp++; if ({res_o, flags_o} !== 21'h0) begin
            n_bad++; $display("FAIL reset_result: got %h/%b want 0000/00000", res_o, flags_o); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_sqrt_exact();
        int lat, c0;
        exp_t x;
        c0 = dosqrt_cnt;
        exp_q.push_back('{16'h4000, 5'b00000});
        accept(16'h4080);
        n_cmp++; if (doSqrt_o !== 1'b1) begin n_bad++; $display("FAIL exact_dosqrt_pulse: got %b want 1", doSqrt_o); end
        core_respond(11, 8'h80, 12'h800, 1'b0, 1'b0, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL exact_latency: got %0d want 2", lat); end
        x = exp_q.pop_front();
        n_cmp++; if (res_o !== x.res) begin n_bad++; $display("FAIL exact_res: got %h want %h", res_o, x.res); end
        n_cmp++; if (flags_o !== x.flags) begin n_bad++; $display("FAIL exact_flags: got %b want %b", flags_o, x.flags); end
        n_cmp++; if (dosqrt_cnt - c0 !== 1) begin n_bad++; $display("FAIL exact_dosqrt_count: got %0d want 1", dosqrt_cnt - c0); end
        release_res();
        n_cmp++; if ({req_ready_o, res_valid_o} !== 2'b10) begin
            n_bad++; $display("FAIL exact_return_idle: got ready=%b valid=%b want 1/0", req_ready_o, res_valid_o); end
    endtask

    typedef struct { logic [7:0] e; logic [11:0] f; logic ov; logic un; logic [15:0] r; logic [4:0] fl; } rnd_t;

    task automatic test_rounding();
        rnd_t tbl[8];
        int lat;
        exp_t x;
        tbl[0] = '{8'h7F, 12'hFF8, 1'b0, 1'b0, 16'h4000, 5'b00010}; // carry out
        tbl[1] = '{8'h80, 12'h808, 1'b0, 1'b0, 16'h4000, 5'b00010}; // tie, even lsb
        tbl[2] = '{8'h80, 12'h818, 1'b0, 1'b0, 16'h4002, 5'b00010}; // tie, odd lsb
        tbl[3] = '{8'h80, 12'h801, 1'b0, 1'b0, 16'h4000, 5'b00010}; // sticky only
        tbl[4] = '{8'hFE, 12'hFF8, 1'b0, 1'b0, 16'h7F80, 5'b01010}; // carry to inf
        tbl[5] = '{8'h80, 12'h800, 1'b1, 1'b0, 16'h7F80, 5'b01010};
        tbl[6] = '{8'h80, 12'h800, 1'b0, 1'b1, 16'h0000, 5'b00110};
        tbl[7] = '{8'h7F, 12'h9A0, 1'b0, 1'b0, 16'h3F9A, 5'b00000};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{tbl[i].r, tbl[i].fl});
            accept(16'h4080);
            core_respond(3, tbl[i].e, tbl[i].f, tbl[i].ov, tbl[i].un, lat);
            x = exp_q.pop_front();
            n_cmp++; if (lat !== 2 || res_o !== x.res || flags_o !== x.flags) begin
                n_bad++; $display("FAIL round_%0d: got lat=%0d %h/%b want lat=2 %h/%b", i, lat, res_o, flags_o, x.res, x.flags); end
            release_res();
        end
    endtask

    task automatic test_special();
        logic [15:0] ops [7] = '{16'hBF80, 16'h8000, 16'h7F80, 16'h7F81, 16'h7FC1, 16'hFF80, 16'h0000};
        logic [15:0] rs  [7] = '{16'h7FC0, 16'h8000, 16'h7F80, 16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h0000};
        logic [4:0]  fs  [7] = '{5'b10000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b10000, 5'b00000};
        int c0;
        exp_t x;
        c0 = dosqrt_cnt;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{rs[i], fs[i]});
            accept(ops[i]);
            x = exp_q.pop_front();
            n_cmp++; if (res_valid_o !== 1'b1 || res_o !== x.res || flags_o !== x.flags) begin
                n_bad++; $display("FAIL special_%h: got valid=%b %h/%b want valid=1 %h/%b",
                                  ops[i], res_valid_o, res_o, flags_o, x.res, x.flags); end
            release_res();
        end
        n_cmp++; if (dosqrt_cnt - c0 !== 0) begin n_bad++; $display("FAIL special_no_dosqrt: got %0d pulses want 0", dosqrt_cnt - c0); end
    endtask

    task automatic test_denormal();
        int lat;
        exp_t x;
        exp_q.push_back('{16'h2000, 5'b00000});
        accept(16'h0001);
        step();
        n_cmp++; if ({signum_op_o, extExp_op_o, extMant_op_o, isInf_op_o, isZero_op_o} !== {1'b0, 9'd1, 8'h01, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL denorm_unpack: got s=%b exp=%h mant=%h inf=%b zero=%b want 0/001/01/0/0",
                              signum_op_o, extExp_op_o, extMant_op_o, isInf_op_o, isZero_op_o); end
        core_respond(2, 8'h40, 12'h800, 1'b0, 1'b0, lat);
        x = exp_q.pop_front();
        n_cmp++; if (lat !== 2 || res_o !== x.res || flags_o !== x.flags) begin
            n_bad++; $display("FAIL denorm_res: got lat=%0d %h/%b want lat=2 %h/%b", lat, res_o, flags_o, x.res, x.flags); end
        release_res();
    endtask

    task automatic test_backpressure();
        int c0;
        exp_t x;
        exp_q.push_back('{16'h7FC0, 5'b10000});
        accept(16'hBF80);
        x = exp_q.pop_front();
        c0 = dosqrt_cnt;
        req_valid_i = 1'b1; op_i = 16'h4080;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (res_valid_o !== 1'b1 || res_o !== x.res || flags_o !== x.flags) begin
                n_bad++; $display("FAIL hold_%0d: got valid=%b %h/%b want 1 %h/%b", i, res_valid_o, res_o, flags_o, x.res, x.flags); end
            n_cmp++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL hold_ready_%0d: got %b want 0", i, req_ready_o); end
        end
        req_valid_i = 1'b0;
        release_res();
        step();
        n_cmp++; if (req_ready_o !== 1'b1 || dosqrt_cnt - c0 !== 0) begin
            n_bad++; $display("FAIL hold_no_accept: got ready=%b pulses=%0d want 1/0", req_ready_o, dosqrt_cnt - c0); end
    endtask

    task automatic test_timeout();
        int n;
        exp_t x;
        exp_q.push_back('{16'h7FC0, 5'b10001});
        accept(16'h4080);
        n = 0;
        while (!res_valid_o && n < 200) begin step(); n++; end
        n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 65", n); end
        x = exp_q.pop_front();
        n_cmp++; if (res_o !== x.res || flags_o !== x.flags) begin
            n_bad++; $display("FAIL timeout_res: got %h/%b want %h/%b", res_o, flags_o, x.res, x.flags); end
        release_res();
    endtask

    task automatic test_reset_mid();
        accept(16'h4080);
        repeat (4) step();
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({req_ready_o, res_valid_o, doSqrt_o} !== 3'b100 ||
                     {signum_op_o, extExp_op_o, extMant_op_o, isInf_op_o, isZero_op_o} !== 20'h0) begin
            n_bad++; $display("FAIL midreset_outs: got rdy=%b vld=%b exp=%h mant=%h want 1/0/000/00",
                              req_ready_o, res_valid_o, extExp_op_o, extMant_op_o); end
        #2 rst = 1'b1;
        step();
        e_res_i = 8'h80; f_res_i = 12'h800; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        repeat (2) step();
        n_cmp++; if ({req_ready_o, res_valid_o, doSqrt_o} !== 3'b100) begin
            n_bad++; $display("FAIL stray_valid: got rdy=%b vld=%b dosqrt=%b want 1/0/0", req_ready_o, res_valid_o, doSqrt_o); end
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_sqrt_exact();
        test_rounding();
        test_special();
        test_denormal();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
